// File: rtl/bram_port_responder.sv
// Toggle-handshake responder that turns one request per port_req level change
// into a single access on a synchronous single-port memory.
module bram_port_responder #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              RESETn,
  input  logic              port_req,
  output logic              port_ack,
  input  logic [22:0]       port_a,
  input  logic [1:0]        port_ds,
  input  logic              port_we,
  input  logic [15:0]       port_d,
  output logic [15:0]       port_q,
  output logic              busy,
  output logic              oob,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q
);

  localparam int unsigned PA_W  = 23;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               req_seen_q, req_seen_d;
  logic               lat_we_q, lat_we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_ack_d;
  logic [15:0]        port_q_d;
  logic               busy_d;
  logic               oob_d;
  logic               mem_en_d;
  logic [1:0]         mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [15:0]        mem_d_d;
  logic [PA_W-1:0]    a_hi;

  // Address bits above the memory's reach; any nonzero bit marks an aliased access
  assign a_hi = port_a >> ADDR_W;

  always_ff @(posedge clk_sys or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      req_seen_q <= 1'b0;
      lat_we_q   <= 1'b0;
      cnt_q      <= '0;
      port_ack   <= 1'b0;
      port_q     <= 16'h0000;
      busy       <= 1'b0;
      oob        <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 2'b00;
      mem_addr   <= '0;
      mem_d      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      lat_we_q   <= lat_we_d;
      cnt_q      <= cnt_d;
      port_ack   <= port_ack_d;
      port_q     <= port_q_d;
      busy       <= busy_d;
      oob        <= oob_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_d      <= mem_d_d;
    end
  end

  // Memory strobes are computed one state ahead so they are registered yet live exactly in ISSUE
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    lat_we_d   = lat_we_q;
    cnt_d      = cnt_q;
    port_ack_d = port_ack;
    port_q_d   = port_q;
    busy_d     = busy;
    oob_d      = oob;
    mem_en_d   = 1'b0;
    mem_we_d   = 2'b00;
    mem_addr_d = mem_addr;
    mem_d_d    = mem_d;

    case (state_q)
      S_IDLE: begin
        if (port_req != req_seen_q) begin
          req_seen_d = port_req;
          lat_we_d   = port_we;
          busy_d     = 1'b1;
          mem_en_d   = 1'b1;
          mem_we_d   = port_we ? port_ds : 2'b00;
          mem_addr_d = port_a[ADDR_W-1:0];
          mem_d_d    = port_d;
          if (a_hi != '0) oob_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = lat_we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          port_q_d   = mem_q;
          port_ack_d = ~port_ack;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        port_ack_d = ~port_ack;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_port_responder.sv
// Randomized scoreboard bench for bram_port_responder with a latency-accurate memory model.
module tb_bram_port_responder;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk_sys = 1'b0;
  logic              RESETn;
  logic              port_req;
  logic              port_ack;
  logic [22:0]       port_a;
  logic [1:0]        port_ds;
  logic              port_we;
  logic [15:0]       port_d;
  logic [15:0]       port_q;
  logic              busy;
  logic              oob;
  logic              mem_en;
  logic [1:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_d;
  logic [15:0]       mem_q;

  bram_port_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys), .RESETn(RESETn),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_we(port_we), .port_d(port_d), .port_q(port_q), .busy(busy), .oob(oob),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        we;
    logic [15:0]       d;
  } iss_t;

  typedef struct {
    logic [15:0] q;
    logic        oob;
    int          ack_cyc;
    int          lat;
  } rsp_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] ref_mem [int];
  logic        ref_oob = 1'b0;
  logic [15:0] last_q  = 16'h0000;
  int          cyc     = 0;
  int          total   = 0;
  int          bad     = 0;

  logic [15:0] mem_arr [DEPTH];
  logic [15:0] pipe [RD_LAT];
  assign mem_q = pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] rd_ref(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 16'h0000;
  endfunction

  // Cycle counter: number of rising edges seen so far
  initial forever begin
    @(posedge clk_sys);
    cyc = cyc + 1;
  end

  // Synchronous memory: byte-enabled write, read data valid RD_LAT edges after the strobe
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_arr[i] = 16'h0000;
    for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= 16'h0000;
    forever begin
      @(posedge clk_sys);
      pipe[0] <= mem_en ? mem_arr[mem_addr] : 16'hDEAD;
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
      if (mem_en && mem_we[1]) mem_arr[mem_addr][15:8] = mem_d[15:8];
      if (mem_en && mem_we[0]) mem_arr[mem_addr][7:0]  = mem_d[7:0];
    end
  end

  // Monitor: compares memory strobes and acknowledges against the scoreboard queues
  initial begin
    logic prev_ack;
    int   busy_cnt;
    iss_t it;
    rsp_t rt;
    prev_ack = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (!RESETn) begin
        prev_ack = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (mem_en) begin
          if (iss_q.size() == 0) flag_fail("spurious_mem_en");
          else begin
            it = iss_q.pop_front();
            check("mem_addr", 32'(mem_addr), 32'(it.addr));
            check("mem_we", 32'(mem_we), 32'(it.we));
            check("mem_d", 32'(mem_d), 32'(it.d));
          end
        end else if (mem_we != 2'b00) begin
          check("mem_we_idle", 32'(mem_we), 32'd0);
        end
        if (port_ack !== prev_ack) begin
          prev_ack = port_ack;
          if (rsp_q.size() == 0) flag_fail("spurious_ack");
          else begin
            rt = rsp_q.pop_front();
            check("ack_cycle", 32'(cyc), 32'(rt.ack_cyc));
            check("port_q", 32'(port_q), 32'(rt.q));
            check("oob", 32'(oob), 32'(rt.oob));
            check("busy_at_ack", 32'(busy), 32'd0);
            check("busy_len", 32'(busy_cnt), 32'(rt.lat));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Drive one request at the current falling edge and record what the spec says must happen
  task automatic issue(input logic we, input logic [22:0] a, input logic [1:0] ds,
                       input logic [15:0] d);
    int          idx;
    int          lat;
    logic [15:0] m;
    iss_t        it;
    rsp_t        rt;
    idx = int'(a % DEPTH);
    m   = {{8{ds[1]}}, {8{ds[0]}}};
    it.addr = ADDR_W'(idx);
    it.we   = we ? ds : 2'b00;
    it.d    = d;
    iss_q.push_back(it);
    if (we) begin
      ref_mem[idx] = (rd_ref(idx) & ~m) | (d & m);
      lat = 2;
    end else begin
      last_q = rd_ref(idx);
      lat = 1 + int'(RD_LAT);
    end
    if ((a / DEPTH) != 0) ref_oob = 1'b1;
    rt.q       = last_q;
    rt.oob     = ref_oob;
    rt.ack_cyc = cyc + 1 + lat;
    rt.lat     = lat;
    rsp_q.push_back(rt);
    port_we  = we;
    port_a   = a;
    port_ds  = ds;
    port_d   = d;
    port_req = ~port_req;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (port_ack !== port_req && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    if (port_ack !== port_req) flag_fail("ack_timeout");
  endtask

  task automatic do_req(input logic we, input logic [22:0] a, input logic [1:0] ds,
                        input logic [15:0] d, input int gap);
    wait_idle();
    repeat (gap) @(negedge clk_sys);
    issue(we, a, ds, d);
  endtask

  initial begin
    int          t0;
    logic [22:0] a;
    RESETn   = 1'b0;
    port_req = 1'b0;
    port_a   = '0;
    port_ds  = 2'b00;
    port_we  = 1'b0;
    port_d   = 16'h0000;

    repeat (3) @(negedge clk_sys);
    check("rst_port_ack", 32'(port_ack), 32'd0);
    check("rst_port_q", 32'(port_q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oob", 32'(oob), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_d", 32'(mem_d), 32'd0);
    RESETn = 1'b1;
    @(negedge clk_sys);

    // Full write then read back
    do_req(1'b1, 23'h0010, 2'b11, 16'hBEEF, 0);
    do_req(1'b0, 23'h0010, 2'b11, 16'h0000, 1);

    // Byte lanes, including an all-lanes-off write
    do_req(1'b1, 23'h0020, 2'b10, 16'h12AB, 0);
    do_req(1'b1, 23'h0020, 2'b01, 16'hCD34, 0);
    do_req(1'b1, 23'h0020, 2'b00, 16'hFFFF, 0);
    do_req(1'b0, 23'h0020, 2'b11, 16'h0000, 0);

    // Aliased address sets the sticky flag
    do_req(1'b1, 23'h8005, 2'b11, 16'h5A5A, 0);
    do_req(1'b0, 23'h0005, 2'b11, 16'h0000, 0);
    do_req(1'b0, 23'h0010, 2'b11, 16'h0000, 2);

    // Back-to-back writes, each toggled as soon as the ack is seen
    wait_idle();
    t0 = cyc;
    for (int i = 0; i < 64; i++)
      do_req(1'b1, 23'(32'h100 + i), 2'b11, 16'($urandom), 0);
    wait_idle();
    check("b2b_span", 32'(cyc - t0), 32'd192);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      a = 23'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | 23'($urandom_range(1, 255) << ADDR_W);
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Reset during a read's WAIT phase, with ack high and port_q nonzero beforehand
    do_req(1'b1, 23'h0010, 2'b11, 16'hBEEF, 0);
    do_req(1'b0, 23'h0010, 2'b11, 16'h0000, 0);
    wait_idle();
    if (port_req == 1'b0) do_req(1'b1, 23'h0011, 2'b11, 16'h1111, 0);
    do_req(1'b0, 23'h0010, 2'b11, 16'h0000, 0);
    repeat (2) @(negedge clk_sys);
    RESETn = 1'b0;
    #1;
    check("abort_port_ack", 32'(port_ack), 32'd0);
    check("abort_port_q", 32'(port_q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oob", 32'(oob), 32'd0);
    rsp_q.delete();
    ref_oob  = 1'b0;
    last_q   = 16'h0000;
    port_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    RESETn = 1'b1;
    issue(1'b0, 23'h0010, 2'b11, 16'h0000);

    wait_idle();
    repeat (5) @(negedge clk_sys);
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("iss_queue_empty", 32'(iss_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
